// File: rtl/s_axis_rq_adapt_x8_pkg.sv
// Shared codes, state enum and descriptor field offsets
// for the x8 requester-request adapter.
package usp_rq_pkg;

  localparam logic [4:0] TYPE_MEM = 5'b00000;
  localparam logic [2:0] FMT_RD3 = 3'b000;
  localparam logic [2:0] FMT_RD4 = 3'b001;
  localparam logic [2:0] FMT_WR3 = 3'b010;
  localparam logic [2:0] FMT_WR4 = 3'b011;

  localparam logic [3:0] REQ_MEM_RD = 4'h0;
  localparam logic [3:0] REQ_MEM_WR = 4'h1;

  localparam int D_ADDR    = 2;
  localparam int D_DWCNT   = 64;
  localparam int D_REQTYPE = 75;
  localparam int D_EP      = 79;
  localparam int D_REQID   = 80;
  localparam int D_TAG     = 96;
  localparam int D_TC      = 121;
  localparam int D_ATTR    = 124;

  typedef enum logic [2:0] {
    SOP, PASS, SHIFT, FLUSH, DROP
  } state_t;

  typedef struct packed {
    logic [127:0] desc;
    logic [3:0]   first_be;
    logic [3:0]   last_be;
    logic         supported;
    logic         is_wr;
    logic         is_4dw;
  } hdr_info_t;

endpackage

// File: rtl/s_axis_rq_adapt_x8_if.sv
// Legacy TLP stream in, RQ stream out; slave is the
// adapter's view, master the core/hard-IP side.
interface s_axis_rq_adapt_x8_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0]    s_axis_rq_tdata;
  logic [KEEP_WIDTH-1:0]    s_axis_rq_tkeep;
  logic                     s_axis_rq_tlast;
  logic                     s_axis_rq_tvalid;
  logic                     s_axis_rq_tready;
  logic [DATA_WIDTH-1:0]    s_axis_rq_tdata_a;
  logic [DATA_WIDTH/32-1:0] s_axis_rq_tkeep_a;
  logic                     s_axis_rq_tlast_a;
  logic [59:0]              s_axis_rq_tuser_a;
  logic                     s_axis_rq_tvalid_a;
  logic [3:0]               s_axis_rq_tready_a;

  modport slave (
    input  s_axis_rq_tdata, s_axis_rq_tkeep,
    input  s_axis_rq_tlast, s_axis_rq_tvalid,
    input  s_axis_rq_tready_a,
    output s_axis_rq_tready,
    output s_axis_rq_tdata_a, s_axis_rq_tkeep_a,
    output s_axis_rq_tlast_a, s_axis_rq_tuser_a,
    output s_axis_rq_tvalid_a
  );

  modport master (
    output s_axis_rq_tdata, s_axis_rq_tkeep,
    output s_axis_rq_tlast, s_axis_rq_tvalid,
    output s_axis_rq_tready_a,
    input  s_axis_rq_tready,
    input  s_axis_rq_tdata_a, s_axis_rq_tkeep_a,
    input  s_axis_rq_tlast_a, s_axis_rq_tuser_a,
    input  s_axis_rq_tvalid_a
  );
endinterface

// File: rtl/s_axis_rq_adapt_x8_desc.sv
// Legacy 3DW/4DW memory request header to 128-bit
// RQ descriptor plus byte enables, purely combinational.
import usp_rq_pkg::*;

module rq_desc_build (
  input  logic [127:0] hdr,
  output hdr_info_t    info
);
  logic [2:0]  fmt;
  logic [4:0]  typ;
  logic [9:0]  len;
  logic [61:0] addr;
  logic        unused_hdr;

  assign fmt = hdr[31:29];
  assign typ = hdr[28:24];
  assign len = hdr[9:0];
  assign unused_hdr = ^{hdr[23], hdr[19:15], hdr[11:10],
                        hdr[65:64], hdr[97:96]};

  always_comb begin
    info = '0;
    info.is_4dw = (fmt == FMT_RD4) || (fmt == FMT_WR4);
    info.is_wr  = (fmt == FMT_WR3) || (fmt == FMT_WR4);
    info.supported = (typ == TYPE_MEM) &&
      (fmt inside {FMT_RD3, FMT_RD4, FMT_WR3, FMT_WR4});
    info.first_be = hdr[35:32];
    info.last_be  = hdr[39:36];
    // 3DW carries only addr[31:2], in DW2
    addr = info.is_4dw ? {hdr[95:64], hdr[127:98]}
                       : {32'b0, hdr[95:66]};
    info.desc[D_ADDR +: 62] = addr;
    info.desc[D_DWCNT +: 11] = (len == 10'd0) ? 11'd1024
                                              : {1'b0, len};
    info.desc[D_REQTYPE +: 4] = info.is_wr ? REQ_MEM_WR
                                           : REQ_MEM_RD;
    info.desc[D_EP] = hdr[14];
    info.desc[D_REQID +: 16] = hdr[63:48];
    info.desc[D_TAG +: 8] = hdr[47:40];
    info.desc[D_TC +: 3] = hdr[22:20];
    info.desc[D_ATTR +: 3] = {1'b0, hdr[13:12]};
  end
endmodule

// File: rtl/s_axis_rq_adapt_x8.sv
// Legacy memory-request TLPs to UltraScale+ RQ beats:
// descriptor first, payload DW-aligned behind it.
import usp_rq_pkg::*;

module s_axis_rq_adapt_x8 #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                 user_clk,
  input  logic                 user_reset,
  s_axis_rq_adapt_x8_if.slave  bus,
  output logic                 unsupported_req
);
  localparam int NDW = KEEP_WIDTH / 4;

  state_t                state, state_n;
  logic [31:0]           carry;
  logic [3:0]            fbe_q, lbe_q;
  logic                  rdy, xfer, load_carry;
  logic                  sop_xfer, unsup_set;
  logic [DATA_WIDTH-1:0] din;
  logic [KEEP_WIDTH-1:0] kin;
  logic [NDW-1:0]        kdw;
  logic                  unused_in;
  hdr_info_t             info;

  assign din = bus.s_axis_rq_tdata;
  assign kin = bus.s_axis_rq_tkeep;
  assign unused_in = ^{kin, bus.s_axis_rq_tready_a[3:1]};

  always_comb begin
    kdw = '0;
    for (int i = 0; i < NDW; i++) kdw[i] = kin[4*i];
  end

  rq_desc_build u_desc (
    .hdr  (din[127:0]),
    .info (info)
  );

  always_comb begin
    rdy = bus.s_axis_rq_tready_a[0];
    if (user_reset) rdy = 1'b0;
    else if (state == DROP) rdy = 1'b1;
    else if (state == FLUSH) rdy = 1'b0;
    else if (state == SOP && !info.supported) rdy = 1'b1;
  end

  assign bus.s_axis_rq_tready = rdy;
  assign xfer = bus.s_axis_rq_tvalid && rdy;

  always_comb begin
    state_n = state;
    load_carry = 1'b0;
    sop_xfer = 1'b0;
    unsup_set = 1'b0;
    bus.s_axis_rq_tvalid_a = bus.s_axis_rq_tvalid;
    bus.s_axis_rq_tdata_a = din;
    bus.s_axis_rq_tkeep_a = kdw;
    bus.s_axis_rq_tlast_a = bus.s_axis_rq_tlast;
    bus.s_axis_rq_tuser_a = {52'b0, lbe_q, fbe_q};
    unique case (state)
      SOP: begin
        sop_xfer = xfer;
        bus.s_axis_rq_tuser_a =
          {52'b0, info.last_be, info.first_be};
        if (!info.supported) begin
          bus.s_axis_rq_tvalid_a = 1'b0;
          unsup_set = xfer;
          if (xfer && !bus.s_axis_rq_tlast) state_n = DROP;
        end else if (!info.is_wr) begin
          bus.s_axis_rq_tdata_a = {128'b0, info.desc};
          bus.s_axis_rq_tkeep_a = 8'h0F;
        end else if (info.is_4dw) begin
          bus.s_axis_rq_tdata_a = {din[255:128], info.desc};
          bus.s_axis_rq_tkeep_a = {kdw[7:4], 4'hF};
          if (xfer && !bus.s_axis_rq_tlast) state_n = PASS;
        end else begin
          // 3DW: payload slips up one DW behind the descriptor
          bus.s_axis_rq_tdata_a = {din[223:96], info.desc};
          bus.s_axis_rq_tkeep_a = {kdw[6:3], 4'hF};
          load_carry = xfer;
          if (bus.s_axis_rq_tlast && kdw[7]) begin
            bus.s_axis_rq_tlast_a = 1'b0;
            if (xfer) state_n = FLUSH;
          end else if (xfer && !bus.s_axis_rq_tlast) begin
            state_n = SHIFT;
          end
        end
      end
      PASS: begin
        if (xfer && bus.s_axis_rq_tlast) state_n = SOP;
      end
      SHIFT: begin
        bus.s_axis_rq_tdata_a = {din[223:0], carry};
        bus.s_axis_rq_tkeep_a = {kdw[6:0], 1'b1};
        load_carry = xfer;
        if (bus.s_axis_rq_tlast && kdw[7]) begin
          bus.s_axis_rq_tlast_a = 1'b0;
          if (xfer) state_n = FLUSH;
        end else if (xfer && bus.s_axis_rq_tlast) begin
          state_n = SOP;
        end
      end
      FLUSH: begin
        bus.s_axis_rq_tvalid_a = 1'b1;
        bus.s_axis_rq_tdata_a = {224'b0, carry};
        bus.s_axis_rq_tkeep_a = 8'h01;
        bus.s_axis_rq_tlast_a = 1'b1;
        if (bus.s_axis_rq_tready_a[0]) state_n = SOP;
      end
      DROP: begin
        bus.s_axis_rq_tvalid_a = 1'b0;
        unsup_set = xfer;
        if (xfer && bus.s_axis_rq_tlast) state_n = SOP;
      end
      default: state_n = SOP;
    endcase
    if (user_reset) bus.s_axis_rq_tvalid_a = 1'b0;
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state <= SOP;
      carry <= '0;
      fbe_q <= '0;
      lbe_q <= '0;
      unsupported_req <= 1'b0;
    end else begin
      state <= state_n;
      if (load_carry) carry <= din[255:224];
      if (sop_xfer) begin
        fbe_q <= info.first_be;
        lbe_q <= info.last_be;
      end
      if (unsup_set) unsupported_req <= 1'b1;
    end
  end
endmodule
